// File: rtl/me_search_ctrl.sv
// Row sequencer for the full-search motion-estimation array: issues one PE row per
// pass, collects each row minimum and keeps the global best SAD and motion vector.
module me_search_ctrl #(
  parameter int MAX_DATA_WIDTH = 16,
  parameter int PE_COUNT       = 16,
  parameter int NUM_ROWS       = 16,
  parameter int ROW_W          = 4,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MAX_DATA_WIDTH-1:0] min_sad,
  input  logic [IDX_W-1:0]          min_idx,
  input  logic                      min_valid,
  output logic                      pe_start,
  output logic [ROW_W-1:0]          row_addr,
  output logic                      busy,
  output logic                      done,
  output logic [MAX_DATA_WIDTH-1:0] best_sad,
  output logic [IDX_W-1:0]          best_mv_x,
  output logic [ROW_W-1:0]          best_mv_y,
  output logic                      timeout_err,
  output logic [2:0]                state_dbg
);

  // Handshake: start is a one-cycle request honoured only in S_IDLE; min_valid is a
  // level that is accepted only after it has been seen low within the current row,
  // so a valid left over from the previous row is never taken twice.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ROW_W:0] LAST_ROW = (ROW_W+1)'(NUM_ROWS - 1);
  localparam logic [7:0]     TMO_MAX  = 8'(TIMEOUT);

  state_t                    state;
  logic                      armed;
  logic [7:0]                tmo_cnt;
  logic [7:0]                tmo_next;
  logic                      accept;
  logic [MAX_DATA_WIDTH-1:0] lat_sad;
  logic [IDX_W-1:0]          lat_idx;

  assign state_dbg = state;
  assign accept    = armed && min_valid;
  assign tmo_next  = tmo_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      tmo_cnt     <= '0;
      lat_sad     <= '0;
      lat_idx     <= '0;
      pe_start    <= 1'b0;
      row_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_sad    <= '0;
      best_mv_x   <= '0;
      best_mv_y   <= '0;
      timeout_err <= 1'b0;
    end else begin
      pe_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row_addr    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            pe_start    <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          armed   <= 1'b0;
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_next;
          if (!min_valid) armed <= 1'b1;
          // Acceptance takes priority over a timeout expiring in the same cycle.
          if (accept) begin
            lat_sad <= min_sad;
            lat_idx <= min_idx;
            state   <= S_UPDATE;
          end else if (tmo_next == TMO_MAX) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_UPDATE: begin
          // Strict compare: a tie keeps the earlier row.
          if (row_addr == '0 || lat_sad < best_sad) begin
            best_sad  <= lat_sad;
            best_mv_x <= lat_idx;
            best_mv_y <= row_addr;
          end
          if ({1'b0, row_addr} == LAST_ROW) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            row_addr <= row_addr + 1'b1;
            pe_start <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: a driver plays the comparator per row from
// tables, a monitor pops expected results from exp_q on every done pulse.
module tb_me_search_ctrl;

  localparam int SW = 16;
  localparam int IW = 4;
  localparam int RW = 4;
  localparam int NR = 16;
  localparam int TO = 8;
  localparam int EW = 1 + SW + IW + RW + 8 + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] min_sad = '0;
  logic [IW-1:0] min_idx = '0;
  logic          min_valid = 1'b0;
  logic          pe_start;
  logic [RW-1:0] row_addr;
  logic          busy;
  logic          done;
  logic [SW-1:0] best_sad;
  logic [IW-1:0] best_mv_x;
  logic [RW-1:0] best_mv_y;
  logic          timeout_err;
  logic [2:0]    state_dbg;

  me_search_ctrl #(
    .MAX_DATA_WIDTH(SW), .PE_COUNT(16), .NUM_ROWS(NR),
    .ROW_W(RW), .IDX_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .min_sad(min_sad), .min_idx(min_idx), .min_valid(min_valid),
    .pe_start(pe_start), .row_addr(row_addr), .busy(busy), .done(done),
    .best_sad(best_sad), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int t_start = 0;
  int pe_cnt = 0;
  int poke_row = -1;

  // mode: 0 normal, 1 stale valid first, 2 never valid, 3 reset during row
  logic [SW-1:0] sad_t[NR];
  logic [IW-1:0] idx_t[NR];
  int            mode_t[NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pk(input bit err, input logic [SW-1:0] s,
                                       input logic [IW-1:0] x, input logic [RW-1:0] y,
                                       input int lat, input int pe);
    return {err, s, x, y, 8'(lat), 5'(pe)};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_pe_start"}, 32'(pe_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_row_addr"}, 32'(row_addr), 0);
    chk({tag, "_best_sad"}, 32'(best_sad), 0);
    chk({tag, "_best_mv_x"}, 32'(best_mv_x), 0);
    chk({tag, "_best_mv_y"}, 32'(best_mv_y), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      pe_cnt = 0;
    end else begin
      if (pe_start) pe_cnt = pe_cnt + 1;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending search (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("timeout_err", 32'(timeout_err), 32'(e[EW-1]));
          chk("best_sad", 32'(best_sad), 32'(e[EW-2 -: SW]));
          chk("best_mv_x", 32'(best_mv_x), 32'(e[EW-2-SW -: IW]));
          chk("best_mv_y", 32'(best_mv_y), 32'(e[EW-2-SW-IW -: RW]));
          chk("done_latency", 32'(cyc - t_start), 32'(e[12:5]));
          chk("pe_start_count", 32'(pe_cnt), 32'(e[4:0]));
          chk("busy_at_done", 32'(busy), 0);
        end
        pe_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_row(input int r, output bit ended);
    bit found = 0;
    ended = 0;
    for (int i = 0; i < 40; i++) begin
      if (pe_start) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL row_issue: got no pe_start expected pulse for row %0d", r);
      ended = 1;
      return;
    end
    case (mode_t[r])
      0: begin
        min_valid = 1'b0;
        @(negedge clk);
        if (r == poke_row) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        min_valid = 1'b1; min_sad = sad_t[r]; min_idx = idx_t[r];
        @(negedge clk);
        min_valid = 1'b0;
      end
      1: begin
        min_valid = 1'b1; min_sad = '0; min_idx = '1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        min_valid = 1'b0;
        @(negedge clk);
        min_valid = 1'b1; min_sad = sad_t[r]; min_idx = idx_t[r];
        @(negedge clk);
        min_valid = 1'b0;
      end
      2: begin
        min_valid = 1'b0;
        ended = 1;
      end
      default: begin
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        min_valid = 1'b0;
        rst_n = 1'b1;
        ended = 1;
      end
    endcase
  endtask

  task automatic run_search(input logic [EW-1:0] exp, input bit push, input bit poke_done);
    bit ended;
    bit seen = 0;
    bit ok = 1;
    @(negedge clk);
    if (push) exp_q.push_back(exp);
    t_start = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < NR; r++) begin
      drive_row(r, ended);
      if (ended) break;
    end
    if (!rst_n || !push) return;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 1);
    if (poke_done && seen) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (pe_start || busy) ok = 0;
        @(negedge clk);
      end
      chk("start_in_done_ignored", 32'(ok), 1);
    end
  endtask

  task automatic fill_planted();
    for (int r = 0; r < NR; r++) begin
      sad_t[r] = SW'(100 + r); idx_t[r] = IW'(r); mode_t[r] = 0;
    end
    sad_t[5] = 16'd3; idx_t[5] = 4'd9;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // planted minimum at row 5
    fill_planted();
    run_search(pk(0, 16'd3, 4'd9, 4'd5, 65, 16), 1, 0);

    // tie between rows 2 and 7 keeps row 2
    for (int r = 0; r < NR; r++) begin
      sad_t[r] = 16'd50; idx_t[r] = IW'(r); mode_t[r] = 0;
    end
    sad_t[2] = 16'd10; sad_t[7] = 16'd10;
    run_search(pk(0, 16'd10, 4'd2, 4'd2, 65, 16), 1, 0);

    // stale valid held across ISSUE on row 11
    for (int r = 0; r < NR; r++) begin
      sad_t[r] = SW'(40 + r); idx_t[r] = IW'(15 - r); mode_t[r] = 0;
    end
    sad_t[11] = 16'd20; mode_t[11] = 1;
    run_search(pk(0, 16'd20, 4'd4, 4'd11, 67, 16), 1, 0);

    // row 3 never answers: timeout after 8 WAIT cycles
    for (int r = 0; r < NR; r++) begin
      sad_t[r] = 16'd1; idx_t[r] = 4'd0; mode_t[r] = 0;
    end
    sad_t[0] = 16'd30; idx_t[0] = 4'd1;
    sad_t[1] = 16'd25; idx_t[1] = 4'd2;
    sad_t[2] = 16'd27; idx_t[2] = 4'd3;
    mode_t[3] = 2;
    run_search(pk(1, 16'd25, 4'd2, 4'd1, 22, 4), 1, 0);

    // all-ones SAD at row 0, start poked while busy and in the done cycle
    for (int r = 0; r < NR; r++) begin
      sad_t[r] = 16'hFFFF; idx_t[r] = 4'd1; mode_t[r] = 0;
    end
    idx_t[0] = 4'd6;
    poke_row = 4;
    run_search(pk(0, 16'hFFFF, 4'd6, 4'd0, 65, 16), 1, 1);
    poke_row = -1;

    // reset during row 6, then a fresh complete search
    fill_planted();
    mode_t[6] = 3;
    run_search('0, 0, 0);
    repeat (3) @(negedge clk);
    chk_zero("after_reset");
    fill_planted();
    run_search(pk(0, 16'd3, 4'd9, 4'd5, 65, 16), 1, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
# me_search_ctrl

Row-sequencing controller for the full-search motion-estimation datapath. It steps the 16-PE SAD array through every vertical offset of the search window, one row per pass, and consumes the per-row minimum SAD and winning PE index from the instant-minimum comparator stage. It tracks the global best SAD and its motion vector, and reports the result with a start/done handshake to the frame-level sequencer.

## Interface
- MAX_DATA_WIDTH, 16, SAD width
- PE_COUNT, 16, PEs per row (horizontal offsets 0..PE_COUNT-1)
- NUM_ROWS, 16, vertical offsets per search (legal range 1..2^ROW_W)
- ROW_W, 4, width of row index / vertical MV
- IDX_W, 4, width of PE index / horizontal MV
- TIMEOUT, 255, max cycles to wait for a row result (legal range 1..255)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a search
- min_sad  in  MAX_DATA_WIDTH  row minimum from comparator
- min_idx  in  IDX_W  PE index of row minimum
- min_valid  in  1  comparator masked valid (level)
- pe_start  out  1  one-cycle pulse launching a row in the PE array
- row_addr  out  ROW_W  current vertical offset
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- best_sad  out  MAX_DATA_WIDTH  global minimum SAD
- best_mv_x  out  IDX_W  PE index of global minimum
- best_mv_y  out  ROW_W  row of global minimum
- timeout_err  out  1  sticky: last search aborted on timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, UPDATE, DONE.
- IDLE: start=1 → ISSUE; clear row_addr, timeout_err; set busy. start is ignored in every other state.
- ISSUE: pe_start=1 for exactly this cycle; clear the armed flag and the timeout counter; → WAIT.
- WAIT, armed flag: the flag sets once min_valid is sampled 0. min_valid=1 is accepted only while armed. This rejects stale valid from the previous row.
- WAIT, accept: latch min_sad and min_idx; → UPDATE.
- WAIT, timeout: the counter increments every WAIT cycle. When it reaches TIMEOUT without acceptance, set timeout_err, keep the best_* values, and → DONE. Acceptance in the same cycle as the counter reaching TIMEOUT wins.
- UPDATE, row 0: load the latched SAD, idx and row into best_* unconditionally.
- UPDATE, later rows: replace best_* only if latched SAD < best_sad (strict, unsigned). Ties keep the earlier row.
- UPDATE, next step: if row_addr == NUM_ROWS-1 → DONE; else row_addr+1 → ISSUE.
- DONE: done=1 for one cycle, busy=0; → IDLE. best_* and timeout_err hold until the next accepted start.
- Reset: state IDLE. All outputs 0 (pe_start, busy, done, row_addr, best_sad, best_mv_x, best_mv_y, timeout_err). A reset mid-search aborts with no done pulse.

## Timing
- Cycle 0: start sampled. Cycle 1: ISSUE, pe_start=1, busy=1.
- Per row: 1 (ISSUE) + W (WAIT cycles, including the acceptance cycle) + 1 (UPDATE) cycles.
- Fastest W = 2: valid low in the first WAIT cycle, high in the second.
- Total latency from the start edge to the done pulse: NUM_ROWS·(2+W) + 1 cycles.
- Best case for NUM_ROWS=16: 65 cycles.
- best_* are updated in the UPDATE cycle and visible the next cycle. They are stable when done=1.
- busy is high from cycle 1 through the last UPDATE, and low in DONE.
- start asserted in the same cycle as done is ignored. A new start is accepted from IDLE one cycle later.

## Test plan
- Single search, NUM_ROWS=16, row r returns min_sad=100+r, idx=r, with the minimum planted at row 5 (sad=3, idx=9) → best_sad=3, mv=(9,5), done pulse at cycle 65, exactly 16 pe_start pulses.
- Tie: rows 2 and 7 both return sad=10, all others 50 → mv_y=2 (earlier row kept).
- Stale valid: min_valid held high across ISSUE into WAIT → not accepted until it drops and rises again; the row count remains 16.
- Timeout: TIMEOUT=8, row 3 never returns valid → after 8 WAIT cycles done=1, timeout_err=1, best_* reflect rows 0-2 only.
- Reset mid-search: rst_n low during row 6 → all outputs 0 immediately, no done pulse. A fresh start after reset completes normally.
- start pulsed while busy and in the done cycle → ignored, no extra pe_start. All-ones SAD at row 0 → still loaded, with mv equal to the row 0 index.
